ram_port_arbiter: RTL
=====================

# ram_port_arbiter

Round-robin arbiter and access sequencer that shares the single port of the 4-byte RAM among four requesters. Each cycle it either idles or owns the RAM for exactly one transaction. It drives the 4:1 select pair (s1 MSB, s0 LSB) and the active-low enable that steer the RAM's byte-select mux. It returns read data and a one-cycle completion pulse to the winning requester.

## Interface
- DATA_W, 8, byte width of RAM data
- ADDR_W, 2, RAM byte address width; requester count is fixed at 4 (one per 4:1 mux leg)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- req  input  4  request per requester, level, held until done
- req_we  input  4  per-requester write flag, sampled with req
- req_addr  input  4*ADDR_W  per-requester byte address, requester i at bits [i*ADDR_W +: ADDR_W]
- req_wdata  input  4*DATA_W  per-requester write data, same packing
- gnt  output  4  one-hot grant, high for the whole transaction
- done  output  4  one-hot, one-cycle completion pulse
- rdata  output  DATA_W  read data, valid only while done is high
- mem_s1, mem_s0  output  1 each  RAM mux select, MSB/LSB of selected address
- mem_en_n  output  1  RAM mux enable, active low
- mem_we  output  1  RAM write strobe
- mem_wdata  output  DATA_W  RAM write data
- mem_rdata  input  DATA_W  RAM mux output (combinational from select/enable)

## Operation
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - If any req bit is set, pick the winner: first set bit scanning upward from ptr, wrapping 3→0.
  - Latch the winner index, its we, addr and wdata into registers.
  - Go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (one cycle):
  - gnt[w] = 1; mem_en_n = 0; {mem_s1, mem_s0} = latched addr; mem_we = latched we; mem_wdata = latched wdata.
  - At the closing edge, register mem_rdata into rdata if the access is a read; on a write, rdata = 0.
  - Go to RESP.
- RESP (one cycle):
  - gnt[w] stays 1 and done[w] = 1.
  - mem_en_n = 1 and mem_we = 0.
  - ptr <= w+1 mod 4.
  - Go to IDLE.
- Outside ACCESS: mem_en_n = 1, mem_we = 0, selects = 0 and mem_wdata = 0, so a disabled mux outputs 0.
- Request inputs are sampled only in IDLE. Changes during ACCESS/RESP are ignored, and a latched transaction always completes.
- A requester that drops req mid-transaction still receives its done pulse, and its write is still committed.
- A requester must deassert or re-present req after done. If req is still high, it re-competes in the next IDLE at the lowest priority because ptr has advanced past it.

## Timing
- Reset values: state = IDLE, ptr = 0, gnt = 0, done = 0, rdata = 0, mem_en_n = 1, mem_we = 0, mem_s1 = mem_s0 = 0, mem_wdata = 0.
- Reset asserted in any state returns everything to the reset values at the next edge. An in-flight write is aborted if rst coincides with its ACCESS edge.
- Latency for a req first sampled at edge k:
  - gnt is high in cycles k+1 and k+2.
  - The RAM is enabled in cycle k+1.
  - done and rdata are valid in cycle k+2.
  - The next grant can start in cycle k+4 (IDLE occupies k+3).
- Throughput is one transaction per 3 cycles.
- Fairness: with all four requesting continuously, the grant order is 0,1,2,3,0,… Starvation bound is 3 transactions.
- All outputs are registered, or decoded from registered state only. There is no combinational path from req* to any output.

## Structure
- A shared package `ram_pkg` holds:
  - DATA_W, ADDR_W and N_REQ = 4.
  - The FSM state enum (IDLE, ACCESS, RESP).
  - A helper for the packed-bus slice offset.
- One sub-module, `rr_pick4`: purely combinational rotate-priority encoder.
  - Inputs: 4-bit req and 2-bit ptr.
  - Outputs: 2-bit winner index and a valid flag.
- The FSM, latches and output drive live in `ram_port_arbiter`.

## Test plan
- Reset, then idle: all outputs at their reset values, mem_en_n = 1 for 10 cycles with req = 0.
- Single requester write then read:
  - Requester 2 writes addr 3, data 0xA5. In ACCESS, expect gnt = 0100, mem_s1 = 1, mem_s0 = 1, mem_en_n = 0, mem_we = 1.
  - Requester 2 then reads addr 3. The bench RAM model returns 0xA5, so expect done = 0100 with rdata = 0xA5 two cycles after sampling.
- All four req held high from reset: gnts 0001, 0010, 0100, 1000, 0001 at a 3-cycle spacing; each done coincides with the second gnt cycle.
- Wrap-around:
  - ptr = 3 after a grant to requester 2, with req = 0101: requester 0 wins.
  - Next, with req = 0001 only: requester 0 wins again.
- Drop mid-transaction: requester 1 write of 0x3C to addr 1; req[1] falls during ACCESS. Expect done[1] pulse and the bench RAM holds 0x3C at addr 1.
- Reset mid-operation: assert rst during ACCESS of requester 0 with req = 1111. Next cycle all outputs are at reset values; the first grant after release goes to requester 0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the 4-requester RAM port arbiter: widths, FSM states
// and the packed-bus slice helper.
package ram_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned N_REQ  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // Low bit of field idx in a bus that packs equal-width fields side by side.
  function automatic int unsigned slice_lo(input int unsigned idx,
                                           input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick4.sv
// Rotating-priority encoder: picks the first set request at or above ptr,
// wrapping from 3 back to 0.
module rr_pick4
  import ram_pkg::*;
(
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_win,
  output logic       o_valid
);

  logic [1:0] w_idx;

  always_comb begin
    o_win   = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_idx = i_ptr + 2'(k);
      if (!o_valid && i_req[w_idx]) begin
        o_valid = 1'b1;
        o_win   = w_idx;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin owner of the single RAM port: IDLE picks and latches a winner,
// ACCESS drives the byte mux for one cycle, RESP returns done/rdata.
module ram_port_arbiter
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = ram_pkg::DATA_W,
  parameter int unsigned ADDR_W = ram_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_s1,
  output logic                      mem_s0,
  output logic                      mem_en_n,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  state_t              r_state;
  logic [1:0]          r_ptr;
  logic [1:0]          r_win;
  logic                r_we;
  logic [N_REQ-1:0]    r_gnt;
  logic [N_REQ-1:0]    r_done;
  logic [DATA_W-1:0]   r_rdata;
  logic [ADDR_W-1:0]   r_sel;
  logic                r_en_n;
  logic                r_mem_we;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic [1:0]          w_win;
  logic                w_valid;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  rr_pick4 u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_win   (w_win),
    .o_valid (w_valid)
  );

  always_comb begin
    w_sel_we    = req_we[w_win];
    w_sel_addr  = req_addr[slice_lo(32'(w_win), ADDR_W) +: ADDR_W];
    w_sel_wdata = req_wdata[slice_lo(32'(w_win), DATA_W) +: DATA_W];
  end

  // The mux-drive registers double as the latched address/data of the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_win       <= '0;
      r_we        <= 1'b0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_sel       <= '0;
      r_en_n      <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_gnt   <= '0;
          r_done  <= '0;
          r_rdata <= '0;
          if (w_valid) begin
            r_win       <= w_win;
            r_we        <= w_sel_we;
            r_gnt       <= 4'(4'b0001 << w_win);
            r_en_n      <= 1'b0;
            r_mem_we    <= w_sel_we;
            r_sel       <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          r_done      <= r_gnt;
          r_rdata     <= r_we ? '0 : mem_rdata;
          r_en_n      <= 1'b1;
          r_mem_we    <= 1'b0;
          r_sel       <= '0;
          r_mem_wdata <= '0;
          r_state     <= RESP;
        end
        RESP: begin
          r_gnt   <= '0;
          r_done  <= '0;
          r_rdata <= '0;
          r_ptr   <= r_win + 2'd1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign mem_s1    = r_sel[1];
  assign mem_s0    = r_sel[0];
  assign mem_en_n  = r_en_n;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;

endmodule
